// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative unsigned MULTU/DIVU sequencer sharing the main ALU
module muldiv_seq #(
    parameter int         WIDTH   = 32,
    parameter logic [3:0] ALU_ADD = 4'b0010,
    parameter logic [3:0] ALU_SUB = 4'b0110
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero,
    output logic             alu_own,
    output logic [3:0]       alu_cont,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_res
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] divs_q, divs_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH-1:0] sh;
    logic             carry;
    logic             ge;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        work_d     = work_q;
        divs_d     = divs_q;
        count_d    = count_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        alu_cont   = ALU_ADD;
        alu_a      = '0;
        alu_b      = '0;
        sh         = '0;
        carry      = 1'b0;
        ge         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !op[1]) begin
                    divs_d     = b;
                    acc_d      = '0;
                    work_d     = a;
                    count_d    = CW'(WIDTH - 1);
                    div_zero_d = 1'b0;
                    if (!op[0]) begin
                        state_d = S_MUL;
                    end else if (b == '0) begin
                        // Zero divisor skips iteration; result is published immediately.
                        state_d    = S_DONE;
                        hi_d       = a;
                        lo_d       = '1;
                        div_zero_d = 1'b1;
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end

            S_MUL: begin
                alu_cont = ALU_ADD;
                alu_a    = acc_q;
                alu_b    = work_q[0] ? divs_q : '0;
                carry    = (alu_res < acc_q);
                acc_d    = {carry, alu_res[WIDTH-1:1]};
                work_d   = {alu_res[0], work_q[WIDTH-1:1]};
                count_d  = count_q - CW'(1);
                if (count_q == '0) begin
                    state_d = S_DONE;
                    hi_d    = acc_d;
                    lo_d    = work_d;
                end
            end

            S_DIV: begin
                // A set msb means the shifted remainder exceeds WIDTH bits, so it always covers b.
                sh       = {acc_q[WIDTH-2:0], work_q[WIDTH-1]};
                ge       = acc_q[WIDTH-1] || (sh >= divs_q);
                alu_cont = ALU_SUB;
                alu_a    = sh;
                alu_b    = divs_q;
                acc_d    = ge ? alu_res : sh;
                work_d   = {work_q[WIDTH-2:0], ge};
                count_d  = count_q - CW'(1);
                if (count_q == '0) begin
                    state_d = S_DONE;
                    hi_d    = acc_d;
                    lo_d    = work_d;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            work_q     <= '0;
            divs_q     <= '0;
            count_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            work_q     <= work_d;
            divs_q     <= divs_d;
            count_q    <= count_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q == S_MUL) || (state_q == S_DIV);
    assign alu_own  = busy;
    assign done     = (state_q == S_DONE);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq against an arithmetic model
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done, div_zero, alu_own;
    logic [31:0] hi, lo, alu_a, alu_b, alu_res;
    logic [3:0]  alu_cont;

    int errors   = 0;
    int n_checks = 0;
    logic [31:0] prev_hi = 0, prev_lo = 0;

    always #5 clk = ~clk;

    always_comb begin
        if (alu_cont == 4'b0110) alu_res = alu_a - alu_b;
        else                     alu_res = alu_a + alu_b;
    end

    muldiv_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero),
        .alu_own(alu_own), .alu_cont(alu_cont), .alu_a(alu_a), .alu_b(alu_b),
        .alu_res(alu_res)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] eh, output logic [31:0] el, output logic ed);
        logic [63:0] p;
        if (o == 2'b00) begin
            p  = 64'(av) * 64'(bv);
            eh = p[63:32];
            el = p[31:0];
            ed = 1'b0;
        end else if (bv == 0) begin
            eh = av;
            el = 32'hFFFF_FFFF;
            ed = 1'b1;
        end else begin
            eh = av % bv;
            el = av / bv;
            ed = 1'b0;
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                          input logic ed, input bit noise);
        int done_at = 0, dcount = 0, bcount = 0, own_bad = 0;
        int exp_busy, exp_done;
        logic [31:0] got_hi = 0, got_lo = 0;
        logic got_dz = 0;
        exp_busy = (o == 2'b01 && bv == 0) ? 0 : 32;
        exp_done = exp_busy + 1;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (busy) bcount++;
            if (alu_own !== busy) own_bad++;
            if (!alu_own && (alu_cont !== 4'b0010 || alu_a !== 0 || alu_b !== 0)) own_bad++;
            if (done) begin
                dcount++;
                if (done_at == 0) begin
                    done_at = n; got_hi = hi; got_lo = lo; got_dz = div_zero;
                end
            end
            if (n == 10 && exp_busy != 0) begin
                chk({name, " hold_hi"}, hi, prev_hi);
                chk({name, " hold_lo"}, lo, prev_lo);
            end
            a = $urandom; b = $urandom;
            if (noise && n >= 3 && n <= 20) begin
                start = 1'b1; op = 2'($urandom_range(0, 3));
            end else begin
                start = 1'b0;
            end
        end
        chk({name, " done_cycle"}, done_at, exp_done);
        chk({name, " busy_cycles"}, bcount, exp_busy);
        chk({name, " done_pulses"}, dcount, 1);
        chk({name, " hi"}, got_hi, eh);
        chk({name, " lo"}, got_lo, el);
        chk({name, " div_zero"}, got_dz, ed);
        chk({name, " alu_own"}, own_bad, 0);
        prev_hi = eh; prev_lo = el;
    endtask

    initial begin
        vec_t vecs[$];
        logic [31:0] eh, el, av, bv;
        logic ed;
        logic [1:0] o;
        int cnt;

        vecs.push_back('{2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0});
        vecs.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0});
        vecs.push_back('{2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{2'b01, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{2'b01, 32'd3, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b0});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'd1, 1'b0});
        vecs.push_back('{2'b00, 32'd0, 32'h1234_5678, 32'd0, 32'd0, 1'b0});

        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 0; b = 0;
        repeat (2) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst hi", hi, 0);
        chk("rst lo", lo, 0);
        chk("rst div_zero", div_zero, 0);
        chk("rst alu_own", alu_own, 0);
        chk("rst alu_cont", alu_cont, 4'b0010);
        chk("rst alu_a", alu_a, 0);
        chk("rst alu_b", alu_b, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dz, i == 1);

        for (int i = 0; i < 24; i++) begin
            o  = 2'($urandom_range(0, 1));
            av = $urandom;
            case ($urandom_range(0, 3))
                0:       bv = 0;
                1:       bv = $urandom_range(1, 300);
                default: bv = $urandom;
            endcase
            model(o, av, bv, eh, el, ed);
            run_op($sformatf("rnd%0d", i), o, av, bv, eh, el, ed, (i % 3) == 0);
        end

        // Reserved op codes must be ignored in IDLE
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd9;
        cnt = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (n == 3) op = 2'b11;
            if (busy || done) cnt++;
        end
        start = 1'b0; op = 2'b00;
        chk("reserved no_activity", cnt, 0);
        chk("reserved hi_kept", hi, prev_hi);
        chk("reserved lo_kept", lo, prev_lo);

        // Reset in the middle of a multiply aborts it
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("midrst busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst hi", hi, 0);
        chk("midrst lo", lo, 0);
        chk("midrst alu_own", alu_own, 0);
        chk("midrst alu_a", alu_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_hi = 0; prev_lo = 0;
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        chk("midrst no_done", cnt, 0);
        run_op("after_rst 3x3", 2'b00, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
